// File: rtl/vga_score_overlay.sv
// Saturating N-digit BCD score counter rendered as 7-segment glyphs over the VGA raster.
// Pixel path is 2 pix_en beats deep and has no backpressure; the score counter updates on every clk.
module vga_score_overlay #(
  parameter int          DIGITS       = 3,
  parameter int          ORIGIN_X     = 5,
  parameter int          ORIGIN_Y     = 5,
  parameter int          SEG_L        = 50,
  parameter int          SEG_W        = 5,
  parameter int          PITCH        = 64,
  parameter int          FLASH_FRAMES = 16,
  parameter int          BLANK_LEAD   = 1,
  parameter logic [7:0]  COLOR        = 8'hE0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic [9:0]            CounterX,
  input  logic [9:0]            CounterY,
  input  logic                  inDisplayArea,
  input  logic                  score_inc,
  input  logic                  score_clr,
  input  logic                  flash_en,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  score_max,
  output logic                  pix_on,
  output logic [7:0]            rgb
);

  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BOX_W = SEG_L + SEG_W;
  localparam int BOX_H = 2 * SEG_L + SEG_W;
  localparam logic [9:0] LIM_W  = 10'(SEG_W);
  localparam logic [9:0] LIM_L  = 10'(SEG_L);
  localparam logic [9:0] LIM_LW = 10'(SEG_L + SEG_W);
  localparam logic [9:0] LIM_2L = 10'(2 * SEG_L);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("DIGITS must be 1..4");
  end
  if (PITCH < BOX_W + 1) begin : g_bad_pitch
    $error("PITCH too small, digit boxes would overlap");
  end
  if (ORIGIN_X + (DIGITS - 1) * PITCH + BOX_W > 1023 || ORIGIN_Y + BOX_H > 1023) begin : g_bad_box
    $error("digit boxes exceed the 10-bit raster");
  end
  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : g_bad_flash
    $error("FLASH_FRAMES must be 1..255");
  end

  // Score counter: nibble i (from the LSB) is digit DIGITS-1-i
  logic [4*DIGITS-1:0] score_nxt;
  logic                carry;

  always_comb begin
    score_nxt = score_bcd;
    carry     = 1'b1;
    score_max = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_bcd[4*i +: 4] != 4'd9) score_max = 1'b0;
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_nxt[4*i +: 4] = 4'd0;
        end else begin
          score_nxt[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       score_bcd <= '0;
    else if (score_clr)              score_bcd <= '0;
    else if (score_inc && !score_max) score_bcd <= score_nxt;
  end

  // Flash phase: flash_on=1 means glyphs are drawn
  logic [7:0] frame_cnt;
  logic       flash_on;
  logic       frame_tick;

  assign frame_tick = pix_en && (CounterX == 10'd0) && (CounterY == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      flash_on  <= 1'b1;
    end else if (!flash_en) begin
      frame_cnt <= 8'd0;
      flash_on  <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == 8'(FLASH_FRAMES - 1)) begin
        frame_cnt <= 8'd0;
        flash_on  <= ~flash_on;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Stage 1: locate the digit box and local coordinates
  logic          box_hit;
  logic [DW-1:0] box_dig;
  logic [9:0]    box_lx, box_ly, x0, y0, dx, dy;

  always_comb begin
    box_hit = 1'b0;
    box_dig = '0;
    box_lx  = '0;
    box_ly  = '0;
    x0      = '0;
    y0      = 10'(ORIGIN_Y);
    dy      = CounterY - y0;
    dx      = '0;
    for (int d = 0; d < DIGITS; d++) begin
      x0 = 10'(ORIGIN_X + d * PITCH);
      dx = CounterX - x0;
      if (CounterX >= x0 && dx <= 10'(BOX_W) && CounterY >= y0 && dy <= 10'(BOX_H)) begin
        box_hit = 1'b1;
        box_dig = DW'(d);
        box_lx  = dx;
        box_ly  = dy;
      end
    end
  end

  logic          s1_vld, s1_hit, s1_de;
  logic [DW-1:0] s1_dig;
  logic [9:0]    s1_lx, s1_ly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_de  <= 1'b0;
      s1_dig <= '0;
      s1_lx  <= '0;
      s1_ly  <= '0;
    end else if (pix_en) begin
      s1_vld <= 1'b1;
      s1_hit <= box_hit;
      s1_de  <= inDisplayArea;
      s1_dig <= box_dig;
      s1_lx  <= box_lx;
      s1_ly  <= box_ly;
    end
  end

  // Stage 2: digit value, leading-zero visibility, segment decode
  logic       any_nz, dig_vis, seg_hit, pix_nxt;
  logic [3:0] dig_val;
  logic [6:0] segs, seg_area;

  always_comb begin
    any_nz  = 1'b0;
    dig_val = 4'd0;
    dig_vis = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      any_nz = any_nz || (score_bcd[4*(DIGITS-1-d) +: 4] != 4'd0);
      if (s1_dig == DW'(d)) begin
        dig_val = score_bcd[4*(DIGITS-1-d) +: 4];
        dig_vis = any_nz || (d == DIGITS - 1) || (BLANK_LEAD == 0);
      end
    end
    case (dig_val)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    // {a,b,c,d,e,f,g}
    seg_area[6] = (s1_ly <= LIM_W);
    seg_area[5] = (s1_lx >= LIM_L) && (s1_ly <= LIM_LW);
    seg_area[4] = (s1_lx >= LIM_L) && (s1_ly >= LIM_L);
    seg_area[3] = (s1_ly >= LIM_2L);
    seg_area[2] = (s1_lx <= LIM_W) && (s1_ly >= LIM_L);
    seg_area[1] = (s1_lx <= LIM_W) && (s1_ly <= LIM_LW);
    seg_area[0] = (s1_ly >= LIM_L) && (s1_ly <= LIM_LW);
    seg_hit = |(segs & seg_area);
    pix_nxt = s1_vld && s1_hit && s1_de && dig_vis && seg_hit && flash_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_on <= 1'b0;
      rgb    <= 8'h00;
    end else if (pix_en) begin
      pix_on <= pix_nxt;
      rgb    <= pix_nxt ? COLOR : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_score_overlay.sv
// Scoreboard bench for vga_score_overlay: stimulus queues expected results tagged with a cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_score_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  CounterX, CounterY;
  logic        inDisplayArea;
  logic        score_inc, score_clr, flash_en;
  logic [11:0] score_bcd, score_bcd_nb;
  logic        score_max, score_max_nb;
  logic        pix_on, pix_on_nb;
  logic [7:0]  rgb, rgb_nb;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_score_overlay u_dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .score_inc(score_inc), .score_clr(score_clr), .flash_en(flash_en),
    .score_bcd(score_bcd), .score_max(score_max), .pix_on(pix_on), .rgb(rgb)
  );

  vga_score_overlay #(.BLANK_LEAD(0)) u_nb (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .score_inc(score_inc), .score_clr(score_clr), .flash_en(flash_en),
    .score_bcd(score_bcd_nb), .score_max(score_max_nb), .pix_on(pix_on_nb), .rgb(rgb_nb)
  );

  // kind: 0 = pixel (main), 1 = score, 2 = pixel (no blanking), 3 = all outputs during reset
  typedef struct {
    int          at;
    int          kind;
    logic [11:0] score;
    logic        mx;
    logic        on;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else if (e.kind == 0 && (pix_on !== e.on || rgb !== (e.on ? 8'hE0 : 8'h00))) begin
        bad++;
        $display("FAIL %s: pix_on=%0b rgb=%h, expected pix_on=%0b rgb=%h",
                 e.name, pix_on, rgb, e.on, e.on ? 8'hE0 : 8'h00);
      end else if (e.kind == 2 && (pix_on_nb !== e.on || rgb_nb !== (e.on ? 8'hE0 : 8'h00))) begin
        bad++;
        $display("FAIL %s: pix_on=%0b rgb=%h, expected pix_on=%0b rgb=%h",
                 e.name, pix_on_nb, rgb_nb, e.on, e.on ? 8'hE0 : 8'h00);
      end else if (e.kind == 1 && (score_bcd !== e.score || score_max !== e.mx)) begin
        bad++;
        $display("FAIL %s: score_bcd=%h score_max=%0b, expected score_bcd=%h score_max=%0b",
                 e.name, score_bcd, score_max, e.score, e.mx);
      end else if (e.kind == 3 && (pix_on !== 1'b0 || rgb !== 8'h00 || score_bcd !== e.score || score_max !== 1'b0)) begin
        bad++;
        $display("FAIL %s: pix_on=%0b rgb=%h score_bcd=%h score_max=%0b, expected all zero",
                 e.name, pix_on, rgb, score_bcd, score_max);
      end
    end
  end

  task automatic push(input int dly, input int kind, input logic [11:0] s, input logic mx,
                      input logic on, input string nm);
    exp_t x;
    x.at = cyc + dly; x.kind = kind; x.score = s; x.mx = mx; x.on = on; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic beat();
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Result of a probe appears at the posedge of the second pix_en beat: 5 cycles on.
  task automatic probe(input int x, input int y, input logic de, input logic on,
                       input int on_nb, input string nm);
    CounterX = 10'(x); CounterY = 10'(y); inDisplayArea = de;
    push(5, 0, 12'h000, 1'b0, on, nm);
    if (on_nb >= 0) push(5, 2, 12'h000, 1'b0, on_nb[0], {nm, "_nb"});
    beat();
    beat();
  endtask

  task automatic ticks(input int n);
    CounterX = 10'd0; CounterY = 10'd0; inDisplayArea = 1'b0;
    repeat (n) beat();
  endtask

  task automatic set_score(input int n, input logic [11:0] s, input string nm);
    push(1 + n, 1, s, 1'b0, 1'b0, nm);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    score_inc = 1'b1;
    repeat (n) @(negedge clk);
    score_inc = 1'b0;
  endtask

  logic [11:0] inc_tab [12] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
                                12'h007, 12'h008, 12'h009, 12'h010, 12'h011, 12'h012};

  initial begin
    reset = 1'b1; pix_en = 1'b0; CounterX = 10'd300; CounterY = 10'd300;
    inDisplayArea = 1'b1; score_inc = 1'b0; score_clr = 1'b0; flash_en = 1'b0;
    push(1, 3, 12'h000, 1'b0, 1'b0, "reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Back-to-back increments, then clear beating increment
    score_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(1, 1, inc_tab[i], 1'b0, 1'b0, "count");
      @(negedge clk);
    end
    score_inc = 1'b0;
    score_clr = 1'b1; score_inc = 1'b1;
    push(1, 1, 12'h000, 1'b0, 1'b0, "clr_wins");
    @(negedge clk);
    score_clr = 1'b0;

    // Saturation at 999
    push(998, 1, 12'h998, 1'b0, 1'b0, "count_998");
    push(999, 1, 12'h999, 1'b1, 1'b0, "count_999");
    repeat (999) @(negedge clk);
    push(3, 1, 12'h999, 1'b1, 1'b0, "saturate");
    repeat (3) @(negedge clk);
    score_inc = 1'b0;

    // Score 007: digit boxes start at x=5, 69, 133 and are 56 wide
    set_score(7, 12'h007, "score_7");
    probe(150, 7, 1'b1, 1'b1, 1, "d2_seg_a");
    probe(5, 7, 1'b1, 1'b0, 1, "d0_lead_zero");
    probe(197, 7, 1'b1, 1'b0, -1, "past_last_box");
    probe(150, 55, 1'b1, 1'b0, -1, "d2_seg_g_unlit");

    // Flash: 16 frame ticks per half-period
    flash_en = 1'b1;
    ticks(16);
    probe(150, 7, 1'b1, 1'b0, -1, "flash_off");
    ticks(16);
    probe(150, 7, 1'b1, 1'b1, -1, "flash_on");
    ticks(16);
    probe(150, 7, 1'b1, 1'b0, -1, "flash_off2");
    flash_en = 1'b0;
    @(negedge clk);
    probe(150, 7, 1'b1, 1'b1, -1, "flash_dropped");

    // Box boundaries with score 008
    push(1, 1, 12'h008, 1'b0, 1'b0, "score_8");
    score_inc = 1'b1;
    @(negedge clk);
    score_inc = 1'b0;
    probe(133, 5, 1'b1, 1'b1, -1, "corner_tl");
    probe(188, 110, 1'b1, 1'b1, -1, "corner_br");
    probe(189, 5, 1'b1, 1'b0, -1, "right_out");
    probe(133, 111, 1'b1, 1'b0, -1, "below_out");
    probe(133, 5, 1'b0, 1'b0, -1, "blanking_area");

    // Reset while a glyph pixel is lit
    probe(150, 7, 1'b1, 1'b1, -1, "lit_before_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    push(0, 3, 12'h000, 1'b0, 1'b0, "async_reset");
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(1, 0, 12'h000, 1'b0, 1'b0, "post_reset_beat1");
    push(5, 0, 12'h000, 1'b0, 1'b1, "post_reset_beat2");
    beat();
    beat();

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
